simmem_wresp_delay_scheduler: RTL and testbench

//  Parametrised write-response scheduler for the simulated memory controller: one slot per outstanding write

---
 rtl/simmem_wresp_delay_scheduler_pkg.sv | 22 ++
 rtl/simmem_wresp_delay_scheduler_if.sv | 42 ++++
 rtl/simmem_wresp_delay_scheduler_age_matrix.sv | 76 +++++++
 rtl/simmem_wresp_delay_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_simmem_wresp_delay_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simmem_wresp_delay_scheduler_pkg.sv
// Shared types and default parameters for the simulated-memory write-response scheduler.
package simmem_pkg;

    localparam int DefNumSlots      = 8;
    localparam int DefIdWidth       = 4;
    localparam int DefDelayWidth    = 8;
    localparam int DefRespDataWidth = 2;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        RESERVED = 2'd1,
        FILLED   = 2'd2
    } slot_state_e;

    typedef struct packed {
        slot_state_e                 state;
        logic [DefIdWidth-1:0]       id;
        logic [DefDelayWidth-1:0]    cnt;
        logic [DefRespDataWidth-1:0] data;
    } slot_t;

endpackage

// File: rtl/simmem_wresp_delay_scheduler_if.sv
// AW/B handshake bundle between requester, scheduler and real memory controller.
interface simmem_wresp_delay_scheduler_if
    import simmem_pkg::*;
#(
    parameter int NumSlots      = DefNumSlots,
    parameter int IdWidth       = DefIdWidth,
    parameter int DelayWidth    = DefDelayWidth,
    parameter int RespDataWidth = DefRespDataWidth
);
    localparam int OccWidth = $clog2(NumSlots + 1);

    logic [DelayWidth-1:0]    delay_i;
    logic                     waddr_in_valid_i;
    logic                     waddr_in_ready_o;
    logic [IdWidth-1:0]       waddr_id_i;
    logic                     waddr_out_valid_o;
    logic                     waddr_out_ready_i;
    logic                     wresp_in_valid_i;
    logic                     wresp_in_ready_o;
    logic [IdWidth-1:0]       wresp_in_id_i;
    logic [RespDataWidth-1:0] wresp_in_data_i;
    logic                     wresp_out_valid_o;
    logic                     wresp_out_ready_i;
    logic [IdWidth-1:0]       wresp_out_id_o;
    logic [RespDataWidth-1:0] wresp_out_data_o;
    logic [OccWidth-1:0]      occupancy_o;

    modport slave (
        input  delay_i, waddr_in_valid_i, waddr_id_i, waddr_out_ready_i,
               wresp_in_valid_i, wresp_in_id_i, wresp_in_data_i, wresp_out_ready_i,
        output waddr_in_ready_o, waddr_out_valid_o, wresp_in_ready_o,
               wresp_out_valid_o, wresp_out_id_o, wresp_out_data_o, occupancy_o
    );

    modport master (
        output delay_i, waddr_in_valid_i, waddr_id_i, waddr_out_ready_i,
               wresp_in_valid_i, wresp_in_id_i, wresp_in_data_i, wresp_out_ready_i,
        input  waddr_in_ready_o, waddr_out_valid_o, wresp_in_ready_o,
               wresp_out_valid_o, wresp_out_id_o, wresp_out_data_o, occupancy_o
    );

endinterface

// File: rtl/simmem_wresp_delay_scheduler_age_matrix.sv
// Age matrix over the slots: older[i][j] = 1 means slot i was reserved before slot j.
// Provides oldest-of-mask selection for the B fill target and the release pick.
module simmem_age_matrix
    import simmem_pkg::*;
#(
    parameter  int NumSlots = DefNumSlots,
    localparam int IdxWidth = $clog2(NumSlots)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               reserve,
    input  logic [IdxWidth-1:0]                reserve_idx,
    input  logic [NumSlots-1:0]                fill_mask,
    input  logic [NumSlots-1:0]                release_mask,
    output logic [NumSlots-1:0][NumSlots-1:0]  older,
    output logic                               fill_found,
    output logic [IdxWidth-1:0]                fill_idx,
    output logic                               rel_found,
    output logic [IdxWidth-1:0]                rel_idx
);

    logic [NumSlots-1:0][NumSlots-1:0] older_r;
    logic [NumSlots-1:0][NumSlots-1:0] older_next_s;

    // Returns {found, index} of the mask member older than every other member.
    function automatic logic [IdxWidth:0] pick_oldest(
        input logic [NumSlots-1:0]               mask,
        input logic [NumSlots-1:0][NumSlots-1:0] mat
    );
        logic [IdxWidth:0] res;
        logic              cand;
        res = {(IdxWidth+1){1'b0}};
        for (int i = 0; i < NumSlots; i++) begin
            cand = mask[i];
            for (int j = 0; j < NumSlots; j++) begin
                cand = cand & ~((j != i) & mask[j] & ~mat[i][j]);
            end
            res = cand ? {1'b1, IdxWidth'(i)} : res;
        end
        return res;
    endfunction

    // Newly reserved slot becomes younger than every other slot.
    always_comb begin
        older_next_s = older_r;
        if (reserve) begin
            for (int i = 0; i < NumSlots; i++) begin
                for (int j = 0; j < NumSlots; j++) begin
                    if (IdxWidth'(i) == reserve_idx) begin
                        older_next_s[i][j] = 1'b0;
                    end else if (IdxWidth'(j) == reserve_idx) begin
                        older_next_s[i][j] = 1'b1;
                    end else begin
                        older_next_s[i][j] = older_r[i][j];
                    end
                end
            end
        end else begin
            older_next_s = older_r;
        end
    end

    // Matrix register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            older_r <= {(NumSlots*NumSlots){1'b0}};
        end else begin
            older_r <= older_next_s;
        end
    end

    assign older                  = older_r;
    assign {fill_found, fill_idx} = pick_oldest(fill_mask, older_r);
    assign {rel_found, rel_idx}   = pick_oldest(release_mask, older_r);

endmodule

// File: rtl/simmem_wresp_delay_scheduler.sv
// Write-response delay scheduler: one slot per outstanding write, released per-ID in AW order after delay.
// Optional statistics counters enabled by defining SIMMEM_WRESP_STATS_EN.
module simmem_wresp_delay_scheduler
    import simmem_pkg::*;
#(
    parameter int NumSlots      = DefNumSlots,
    parameter int IdWidth       = DefIdWidth,
    parameter int DelayWidth    = DefDelayWidth,
    parameter int RespDataWidth = DefRespDataWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    simmem_wresp_delay_scheduler_if.slave  bus
`ifdef SIMMEM_WRESP_STATS_EN
    ,
    output logic [31:0]                    stat_released_o,
    output logic [31:0]                    stat_full_cycles_o
`endif
);

    localparam int IdxWidth = $clog2(NumSlots);
    localparam int OccWidth = $clog2(NumSlots + 1);

    typedef struct packed {
        slot_state_e              state;
        logic [IdWidth-1:0]       id;
        logic [DelayWidth-1:0]    cnt;
        logic [RespDataWidth-1:0] data;
    } slot_entry_t;

    slot_entry_t                       slots_r      [NumSlots];
    slot_entry_t                       slots_next_s [NumSlots];
    logic [NumSlots-1:0]               free_mask_s;
    logic [NumSlots-1:0]               busy_mask_s;
    logic [NumSlots-1:0]               match_mask_s;
    logic [NumSlots-1:0]               elig_mask_s;
    logic [NumSlots-1:0][NumSlots-1:0] older_s;
    logic                              blocked_s;
    logic                              any_free_s;
    logic [IdxWidth-1:0]               free_idx_s;
    logic                              fill_found_s;
    logic [IdxWidth-1:0]               fill_idx_s;
    logic                              rel_found_s;
    logic [IdxWidth-1:0]               rel_idx_s;
    logic                              aw_hs_s;
    logic                              bin_hs_s;
    logic                              bout_hs_s;
    logic                              take_s;
    logic [OccWidth-1:0]               occ_s;
    logic                              lock_r;
    logic [IdxWidth-1:0]               lock_idx_r;
    logic [IdWidth-1:0]                out_id_r;
    logic [RespDataWidth-1:0]          out_data_r;

    // Slot status masks, same-ID ordering check and lowest-free search.
    always_comb begin
        free_idx_s = {IdxWidth{1'b0}};
        blocked_s  = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            free_mask_s[i]  = (slots_r[i].state == FREE);
            busy_mask_s[i]  = (slots_r[i].state != FREE);
            match_mask_s[i] = (slots_r[i].state == RESERVED) && (slots_r[i].id == bus.wresp_in_id_i);
            blocked_s = 1'b0;
            for (int j = 0; j < NumSlots; j++) begin
                blocked_s = blocked_s | ((j != i) && (slots_r[j].state != FREE) &&
                                         (slots_r[j].id == slots_r[i].id) && older_s[j][i]);
            end
            // cnt <= 1 means the counter reaches zero at this edge, so the
            // release lands exactly delay cycles after the AW handshake.
            elig_mask_s[i] = (slots_r[i].state == FILLED) && (slots_r[i].cnt <= DelayWidth'(1)) &&
                             !blocked_s && !(lock_r && (lock_idx_r == IdxWidth'(i)));
        end
        for (int i = NumSlots - 1; i >= 0; i--) begin
            free_idx_s = free_mask_s[i] ? IdxWidth'(i) : free_idx_s;
        end
    end

    assign any_free_s = |free_mask_s;
    assign aw_hs_s    = bus.waddr_in_valid_i & bus.waddr_out_ready_i & any_free_s;
    assign bin_hs_s   = bus.wresp_in_valid_i & (|match_mask_s);
    assign bout_hs_s  = lock_r & bus.wresp_out_ready_i;
    // A handshake this edge frees the output register for the next pick.
    assign take_s     = (~lock_r | bout_hs_s) & rel_found_s;

    simmem_age_matrix #(
        .NumSlots (NumSlots)
    ) u_age (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reserve      (aw_hs_s),
        .reserve_idx  (free_idx_s),
        .fill_mask    (match_mask_s),
        .release_mask (elig_mask_s),
        .older        (older_s),
        .fill_found   (fill_found_s),
        .fill_idx     (fill_idx_s),
        .rel_found    (rel_found_s),
        .rel_idx      (rel_idx_s)
    );

    // Per-slot next state: reserve, countdown, fill and release.
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            slots_next_s[i] = slots_r[i];
            case (slots_r[i].state)
                FREE: begin
                    if (aw_hs_s && (free_idx_s == IdxWidth'(i))) begin
                        slots_next_s[i].state = RESERVED;
                        slots_next_s[i].id    = bus.waddr_id_i;
                        slots_next_s[i].cnt   = bus.delay_i;
                    end else begin
                        slots_next_s[i].state = FREE;
                    end
                end
                RESERVED: begin
                    slots_next_s[i].cnt = (slots_r[i].cnt != {DelayWidth{1'b0}}) ?
                                          slots_r[i].cnt - DelayWidth'(1) : slots_r[i].cnt;
                    if (bin_hs_s && fill_found_s && (fill_idx_s == IdxWidth'(i))) begin
                        slots_next_s[i].state = FILLED;
                        slots_next_s[i].data  = bus.wresp_in_data_i;
                    end else begin
                        slots_next_s[i].state = RESERVED;
                    end
                end
                FILLED: begin
                    slots_next_s[i].cnt = (slots_r[i].cnt != {DelayWidth{1'b0}}) ?
                                          slots_r[i].cnt - DelayWidth'(1) : slots_r[i].cnt;
                    if (bout_hs_s && (lock_idx_r == IdxWidth'(i))) begin
                        slots_next_s[i].state = FREE;
                    end else begin
                        slots_next_s[i].state = FILLED;
                    end
                end
                default: begin
                    slots_next_s[i].state = FREE;
                end
            endcase
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                slots_r[i] <= '{state: FREE, id: {IdWidth{1'b0}}, cnt: {DelayWidth{1'b0}},
                                data: {RespDataWidth{1'b0}}};
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                slots_r[i] <= slots_next_s[i];
            end
        end
    end

    // Output lock: holds the released response stable until the requester accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r     <= 1'b0;
            lock_idx_r <= {IdxWidth{1'b0}};
            out_id_r   <= {IdWidth{1'b0}};
            out_data_r <= {RespDataWidth{1'b0}};
        end else if (take_s) begin
            lock_r     <= 1'b1;
            lock_idx_r <= rel_idx_s;
            out_id_r   <= slots_r[rel_idx_s].id;
            out_data_r <= slots_r[rel_idx_s].data;
        end else if (bout_hs_s) begin
            lock_r     <= 1'b0;
        end else begin
            lock_r     <= lock_r;
        end
    end

    // Occupancy is the population count of non-FREE slots.
    always_comb begin
        occ_s = {OccWidth{1'b0}};
        for (int i = 0; i < NumSlots; i++) begin
            occ_s = occ_s + OccWidth'(busy_mask_s[i]);
        end
    end

    assign bus.waddr_out_valid_o = bus.waddr_in_valid_i & any_free_s;
    assign bus.waddr_in_ready_o  = bus.waddr_out_ready_i & any_free_s;
    assign bus.wresp_in_ready_o  = |match_mask_s;
    assign bus.wresp_out_valid_o = lock_r;
    assign bus.wresp_out_id_o    = out_id_r;
    assign bus.wresp_out_data_o  = out_data_r;
    assign bus.occupancy_o       = occ_s;

`ifdef SIMMEM_WRESP_STATS_EN
    logic [31:0] stat_released_r;
    logic [31:0] stat_full_cycles_r;

    // Release counter wraps; full-stall counter saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_released_r    <= 32'd0;
            stat_full_cycles_r <= 32'd0;
        end else begin
            stat_released_r    <= bout_hs_s ? stat_released_r + 32'd1 : stat_released_r;
            stat_full_cycles_r <= (bus.waddr_in_valid_i && !any_free_s &&
                                   (stat_full_cycles_r != 32'hFFFF_FFFF)) ?
                                  stat_full_cycles_r + 32'd1 : stat_full_cycles_r;
        end
    end

    assign stat_released_o    = stat_released_r;
    assign stat_full_cycles_o = stat_full_cycles_r;
`endif

endmodule

// File: tb/tb_simmem_wresp_delay_scheduler.sv
// Scoreboard bench for simmem_wresp_delay_scheduler: directed AW/B sequences, monitor checks released responses.
module tb_simmem_wresp_delay_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simmem_wresp_delay_scheduler_if #(.NumSlots(8), .IdWidth(4), .DelayWidth(8), .RespDataWidth(2)) bus ();

`ifdef SIMMEM_WRESP_STATS_EN
    logic [31:0] stat_rel;
    logic [31:0] stat_full;
`endif

    simmem_wresp_delay_scheduler #(
        .NumSlots(8), .IdWidth(4), .DelayWidth(8), .RespDataWidth(2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
`ifdef SIMMEM_WRESP_STATS_EN
        ,
        .stat_released_o    (stat_rel),
        .stat_full_cycles_o (stat_full)
`endif
    );

    typedef struct {
        logic [3:0] id;
        logic [1:0] data;
        time        aw_t;
        int         min_d;
        bit         exact;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         tests_run = 0;
    int         tests_failed = 0;
    bit         showing = 1'b0;
    time        start_t;
    time        last_hs_t = 0;
    logic [3:0] held_id;
    logic [1:0] held_data;
    longint     edges;

    task automatic check(input string name, input longint act, input longint exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input logic [3:0] id, input logic [1:0] data, input time t, input int d, input bit ex);
        exp_t x;
        x.id = id; x.data = data; x.aw_t = t; x.min_d = d; x.exact = ex;
        sb.push_back(x);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [7:0] d, output time t);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        bus.waddr_in_valid_i = 1'b1; bus.waddr_id_i = id; bus.delay_i = d;
        while (n < 100) begin
            @(negedge clk);
            if (bus.waddr_in_ready_o && bus.waddr_out_valid_o) begin ok = 1'b1; break; end
            n++;
        end
        check("aw_accept", ok, 1);
        @(posedge clk);
        t = $time;
        #1 bus.waddr_in_valid_i = 1'b0;
    endtask

    task automatic do_bin(input logic [3:0] id, input logic [1:0] data);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        bus.wresp_in_valid_i = 1'b1; bus.wresp_in_id_i = id; bus.wresp_in_data_i = data;
        while (n < 100) begin
            @(negedge clk);
            if (bus.wresp_in_ready_o) begin ok = 1'b1; break; end
            n++;
        end
        check("bin_accept", ok, 1);
        @(posedge clk);
        #1 bus.wresp_in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.wresp_out_valid_o) begin ok = 1'b1; break; end
            n++;
        end
        check("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    // Monitor: stability while held, scoreboard compare on each B-out handshake.
    always @(negedge clk) begin
        if (rst) begin
            showing = 1'b0;
        end else if (bus.wresp_out_valid_o) begin
            if (!showing) begin
                showing   = 1'b1;
                start_t   = $time;
                held_id   = bus.wresp_out_id_o;
                held_data = bus.wresp_out_data_o;
            end else begin
                check("out_id_stable", bus.wresp_out_id_o, held_id);
                check("out_data_stable", bus.wresp_out_data_o, held_data);
            end
            if (bus.wresp_out_ready_i) begin
                last_hs_t = $time;
                showing   = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", bus.wresp_out_id_o, e.id);
                    check("resp_data", bus.wresp_out_data_o, e.data);
                    edges = longint'((start_t - e.aw_t - 5) / 10);
                    if (e.exact) check("release_cycle", edges, e.min_d);
                    else         check("release_not_early", edges >= e.min_d, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_a, t_b;
        bus.delay_i = 8'd0; bus.waddr_in_valid_i = 1'b0; bus.waddr_id_i = 4'd0;
        bus.waddr_out_ready_i = 1'b1; bus.wresp_in_valid_i = 1'b0; bus.wresp_in_id_i = 4'd0;
        bus.wresp_in_data_i = 2'd0; bus.wresp_out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.wresp_out_valid_o, 0);
        check("rst_in_ready_b", bus.wresp_in_ready_o, 0);
        check("rst_aw_out_valid", bus.waddr_out_valid_o, 0);
        check("rst_aw_in_ready", bus.waddr_in_ready_o, 1);
        check("rst_occupancy", bus.occupancy_o, 0);
        bus.waddr_out_ready_i = 1'b0;
        #1 check("aw_ready_follows", bus.waddr_in_ready_o, 0);
        bus.waddr_out_ready_i = 1'b1;
        @(posedge clk); #1;

        // Delay 5, B one cycle later: valid first visible 5 edges after AW
        do_aw(4'd3, 8'd5, t_a);
        do_bin(4'd3, 2'b10);
        push(4'd3, 2'b10, t_a, 5, 1'b1);
        drain();

        // Same ID: long delay then zero delay must stay in AW order
        do_aw(4'd2, 8'd10, t_a);
        do_aw(4'd2, 8'd0, t_b);
        push(4'd2, 2'b01, t_a, 10, 1'b0);
        push(4'd2, 2'b11, t_b, 0, 1'b0);
        do_bin(4'd2, 2'b01);
        do_bin(4'd2, 2'b11);
        drain();

        // Distinct IDs: short delay overtakes long delay
        do_aw(4'd5, 8'd8, t_a);
        do_aw(4'd6, 8'd1, t_b);
        push(4'd6, 2'b01, t_b, 1, 1'b0);
        push(4'd5, 2'b00, t_a, 8, 1'b0);
        do_bin(4'd5, 2'b00);
        do_bin(4'd6, 2'b01);
        drain();

        // Fill all slots, then one release lets the next AW in the following cycle
        for (int i = 0; i < 8; i++) begin
            do_aw(4'(i), 8'd0, t_a);
        end
        @(negedge clk);
        check("full_occupancy", bus.occupancy_o, 8);
        bus.waddr_in_valid_i = 1'b1; bus.waddr_id_i = 4'd9; bus.delay_i = 8'd0;
        #1;
        check("full_aw_ready", bus.waddr_in_ready_o, 0);
        check("full_aw_out_valid", bus.waddr_out_valid_o, 0);
        @(posedge clk); #1;
        push(4'd0, 2'b01, 0, 0, 1'b0);
        do_bin(4'd0, 2'b01);
        do_aw(4'd9, 8'd0, t_b);
        check("aw_after_release", longint'(t_b), longint'(last_hs_t + 15));
        for (int i = 1; i < 8; i++) begin
            push(4'(i), 2'(i), 0, 0, 1'b0);
        end
        push(4'd9, 2'b10, 0, 0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            do_bin(4'(i), 2'(i));
        end
        do_bin(4'd9, 2'b10);
        drain();

        // Unknown ID stalls; held output stays stable while requester is not ready
        do_aw(4'd4, 8'd0, t_a);
        bus.wresp_in_valid_i = 1'b1; bus.wresp_in_id_i = 4'd7; bus.wresp_in_data_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("unknown_id_ready", bus.wresp_in_ready_o, 0);
        end
        @(posedge clk); #1;
        bus.wresp_in_valid_i = 1'b0;
        bus.wresp_out_ready_i = 1'b0;
        push(4'd4, 2'b11, t_a, 0, 1'b0);
        do_bin(4'd4, 2'b11);
        repeat (6) @(posedge clk);
        #1;
        check("stall_valid_held", bus.wresp_out_valid_o, 1);
        bus.wresp_out_ready_i = 1'b1;
        drain();

        // Reset with four filled slots discards them
        for (int i = 0; i < 4; i++) begin
            do_aw(4'(i + 10), 8'd20, t_a);
        end
        for (int i = 0; i < 4; i++) begin
            do_bin(4'(i + 10), 2'b01);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_occupancy", bus.occupancy_o, 0);
        check("mid_rst_out_valid", bus.wresp_out_valid_o, 0);
        check("mid_rst_aw_ready", bus.waddr_in_ready_o, 1);
        check("mid_rst_b_ready", bus.wresp_in_ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_occupancy", bus.occupancy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
